// File: rtl/native_uart_tx_if.sv
// -----------------------------------------------------------------------------
// native_mem_if
// PicoRV32 native memory interface bundle.
//
// Signals:
//   mem_valid  initiator request
//   mem_ready  responder acknowledge, one-cycle pulse
//   mem_addr   byte address
//   mem_wdata  write data
//   mem_wstrb  byte strobes; 0 = read
//   mem_rdata  read data, valid while mem_ready = 1
//
// Modports:
//   master  initiator side (CPU / testbench)
//   slave   responder side (peripheral)
// -----------------------------------------------------------------------------
interface native_mem_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/native_uart_tx.sv
// -----------------------------------------------------------------------------
// native_uart_tx
// UART transmitter on the PicoRV32 native memory bus. The CPU pushes bytes
// into a small TX FIFO; a serializer drains it onto `tx` as 8N1 frames,
// LSB first. Register window of 16 bytes at BASE_ADDR:
//   +0x0 TXDATA  W   push wdata[7:0] (stalls while the FIFO is full)
//   +0x4 STATUS  R   bit0 busy, bit1 full, bit2 empty, bit3 parity enabled
//   +0x8 CLKDIV  R/W clocks per bit, 16 bits, 0 is stored as 1
//   +0xC reserved
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    native memory interface, responder side
//   tx     serial output, idle high
//
// Build option: define UART_TX_PARITY_EN to insert an even parity bit
// between the data bits and the stop bit (8E1 frames).
// -----------------------------------------------------------------------------
module native_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter logic [15:0] CLKDIV_RESET = 16'd16
) (
   input  logic        clk,
   input  logic        reset,
   native_mem_if.slave bus,
   output logic        tx
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

`ifdef UART_TX_PARITY_EN
   localparam logic PARITY_EN = 1'b1;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   localparam logic PARITY_EN = 1'b0;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   // ---------------- FIFO ----------------
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          full, empty;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // ---------------- bus decode ----------------
   state_t      state;
   logic [15:0] clkdiv_q;
   logic        hit, is_write, push_req, accept, push, pop, busy;
   logic [1:0]  offset;
   logic [31:0] rd_val;
   logic [15:0] div_wr;

   assign hit      = bus.mem_valid && (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
   assign offset   = bus.mem_addr[3:2];
   assign is_write = |bus.mem_wstrb;
   assign push_req = is_write && (offset == 2'd0) && bus.mem_wstrb[0];
   // A push into a full FIFO is held off (no ack) until an entry frees.
   // The !mem_ready term keeps a still-asserted mem_valid from being
   // accepted a second time during the ack cycle.
   assign accept   = hit && !bus.mem_ready && !(push_req && full);
   assign push     = accept && push_req;
   assign pop      = (state == S_IDLE) && !empty;
   assign busy     = (state != S_IDLE);

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      rd_val = '0;
      case (offset)
         2'd1:    rd_val = {28'd0, PARITY_EN, empty, full, busy};
         2'd2:    rd_val = {16'd0, clkdiv_q};
         default: rd_val = '0;
      endcase
   end

   // Byte-strobed CLKDIV update; a zero divider would stall the serializer.
   always_comb begin
      div_wr = clkdiv_q;
      if (bus.mem_wstrb[0]) div_wr[7:0]  = bus.mem_wdata[7:0];
      if (bus.mem_wstrb[1]) div_wr[15:8] = bus.mem_wdata[15:8];
      if (div_wr == 16'd0)  div_wr = 16'd1;
   end

   // NOTE: state is updated with non-blocking assignments so every always_ff
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.mem_ready <= 1'b0;
         bus.mem_rdata <= '0;
         clkdiv_q      <= CLKDIV_RESET;
      end else begin
         bus.mem_ready <= accept;
         bus.mem_rdata <= (accept && !is_write) ? rd_val : 32'd0;
         if (accept && is_write && (offset == 2'd2))
            clkdiv_q <= div_wr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the FIFO storage has no reset; contents are only observed behind
   // the pointers, which are reset.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.mem_wdata[7:0];
   end

   // ---------------- serializer ----------------
   logic [15:0] cnt;
   logic [15:0] div_lat;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;

   // Each state holds tx for div_lat cycles: cnt is loaded with div_lat-1 on
   // entry and the state advances when it reaches zero. tx is registered and
   // set on the transition edge, so it lines up with the state it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         tx      <= 1'b1;
         cnt     <= '0;
         div_lat <= 16'd1;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               tx <= 1'b1;
               if (!empty) begin
                  shreg   <= fifo_mem[rd_ptr[AW-1:0]];
                  div_lat <= clkdiv_q;
                  cnt     <= clkdiv_q - 16'd1;
                  tx      <= 1'b0;
                  state   <= S_START;
               end
            end
            S_START: begin
               if (cnt == 16'd0) begin
                  cnt     <= div_lat - 16'd1;
                  bit_idx <= 3'd0;
                  tx      <= shreg[0];
                  state   <= S_DATA;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (cnt == 16'd0) begin
                  cnt <= div_lat - 16'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx    <= ^shreg;
                     state <= S_PARITY;
`else
                     tx    <= 1'b1;
                     state <= S_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (cnt == 16'd0) begin
                  cnt   <= div_lat - 16'd1;
                  tx    <= 1'b1;
                  state <= S_STOP;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
`endif
            S_STOP: begin
               // Returning through IDLE gives exactly one idle cycle between
               // back-to-back frames.
               if (cnt == 16'd0) state <= S_IDLE;
               else              cnt   <= cnt - 16'd1;
            end
            default: begin
               state <= S_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

   // Address bits [1:0] and the upper write-data bytes are intentionally unused.
   logic unused_bits;
   assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata[31:16]};

endmodule
